// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
package truth_table_scanner_pkg;

  localparam int unsigned N_IN_DEFAULT          = 4;
  localparam int unsigned TT_WIDTH              = 2 ** N_IN_DEFAULT;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 2;

  // Golden table of the lab gate Q = AB + BCD (minterms 7, 12..15).
  localparam logic [TT_WIDTH-1:0] LAB_GOLDEN_TT = 16'hF080;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_e;

  function automatic int unsigned settle_cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Handshake/data bundle between a scanner and its controller/DUT side.
// Optional macro TRUTH_TABLE_ERRCNT_EN adds err_count.
interface truth_table_scanner_if #(
  parameter int unsigned N_IN = 4
);
  localparam int unsigned TW = 2 ** N_IN;

  logic            start;
  logic [TW-1:0]   expected;
  logic            q_in;
  logic [N_IN-1:0] abcd_out;
  logic            busy;
  logic            done;
  logic [TW-1:0]   table_out;
  logic            match;
`ifdef TRUTH_TABLE_ERRCNT_EN
  logic [N_IN:0]   err_count;

  modport master (
    output start, expected, q_in,
    input  abcd_out, busy, done, table_out, match, err_count
  );
  modport slave (
    input  start, expected, q_in,
    output abcd_out, busy, done, table_out, match, err_count
  );
`else
  modport master (
    output start, expected, q_in,
    input  abcd_out, busy, done, table_out, match
  );
  modport slave (
    input  start, expected, q_in,
    output abcd_out, busy, done, table_out, match
  );
`endif

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable up/down counter with clear and terminal-count flag.
module truth_table_scanner_settle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + W'(1) : cnt - W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all input vectors over a combinational DUT and compares the captured
// truth table with a golden one. Optional macro TRUTH_TABLE_ERRCNT_EN adds err_count.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_scanner_if.slave bus
);

  localparam int unsigned     TW       = 2 ** N_IN;
  localparam int unsigned     CW       = settle_cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  scan_state_e     state;
  logic [N_IN-1:0] index;
  logic [TW-1:0]   exp_reg;
  logic [TW-1:0]   table_q;
  logic            busy_q;
  logic            done_q;
  logic            match_q;

  logic [CW-1:0]   cnt;
  logic            cnt_tc;
  logic            accept;
  logic            timer_clr;
  logic            timer_en;

  assign accept    = (state == IDLE) && bus.start;
  // Holding the count at its terminal value keeps it bounded while the FSM leaves SETTLE.
  assign timer_clr = accept || (state == SAMPLE);
  assign timer_en  = (state == SETTLE) && !cnt_tc;

  truth_table_scanner_settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (timer_en),
    .up       (1'b1),
    .term     (CNT_LAST),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      exp_reg <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            index   <= '0;
            table_q <= '0;
            match_q <= 1'b0;
            exp_reg <= bus.expected;
            busy_q  <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_q[index] <= bus.q_in;
          if (index == IDX_LAST) begin
            state <= DONE;
          end else begin
            index <= index + N_IN'(1);
            state <= SETTLE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          match_q <= (table_q == exp_reg);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.abcd_out  = index;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.match     = match_q;

`ifdef TRUTH_TABLE_ERRCNT_EN
  logic [N_IN:0] err_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_q <= '0;
    end else if ((state == SAMPLE) && (bus.q_in != exp_reg[index])) begin
      err_q <= err_q + (N_IN + 1)'(1);
    end
  end

  assign bus.err_count = err_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized self-checking bench: three scanners (settle 2, 1, 5) share stimulus.
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic [15:0] lut;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        done_w  [3];
  logic        busy_w  [3];
  logic        match_w [3];
  logic [15:0] table_w [3];
  logic [3:0]  abcd_w  [3];
`ifdef TRUTH_TABLE_ERRCNT_EN
  logic [4:0]  err_w   [3];
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned SC = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    truth_table_scanner_if #(.N_IN(4)) bus ();
    assign bus.start    = start;
    assign bus.expected = expected;
    assign bus.q_in     = lut[bus.abcd_out];
    truth_table_scanner #(
      .N_IN          (4),
      .SETTLE_CYCLES (SC)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign done_w[g]  = bus.done;
    assign busy_w[g]  = bus.busy;
    assign match_w[g] = bus.match;
    assign table_w[g] = bus.table_out;
    assign abcd_w[g]  = bus.abcd_out;
`ifdef TRUTH_TABLE_ERRCNT_EN
    assign err_w[g]   = bus.err_count;
`endif
  end

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  function automatic logic [15:0] tt_lab();
    logic [15:0] t;
    logic [3:0]  v;
    for (int i = 0; i < TT_WIDTH; i++) begin
      v    = i[3:0];
      t[i] = (v[3] & v[2]) | (v[2] & v[1] & v[0]);
    end
    return t;
  endfunction

  function automatic logic [15:0] tt_xor_ad();
    logic [15:0] t;
    logic [3:0]  v;
    for (int i = 0; i < TT_WIDTH; i++) begin
      v    = i[3:0];
      t[i] = v[3] ^ v[0];
    end
    return t;
  endfunction

  function automatic int popcount16(input logic [15:0] x);
    int n = 0;
    for (int i = 0; i < 16; i++) n += x[i];
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    else
      n_pass++;
  endtask

  task automatic check_idle_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_busy_s%0d", name, settle_of(k)), busy_w[k], 0);
      check_eq($sformatf("%s_done_s%0d", name, settle_of(k)), done_w[k], 0);
      check_eq($sformatf("%s_table_s%0d", name, settle_of(k)), table_w[k], 0);
      check_eq($sformatf("%s_match_s%0d", name, settle_of(k)), match_w[k], 0);
      check_eq($sformatf("%s_abcd_s%0d", name, settle_of(k)), abcd_w[k], 0);
`ifdef TRUTH_TABLE_ERRCNT_EN
      check_eq($sformatf("%s_err_s%0d", name, settle_of(k)), err_w[k], 0);
`endif
    end
  endtask

  task automatic watch_no_done(input string name, input int ncyc);
    int seen = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (done_w[k]) seen++;
    end
    check_eq({name, "_no_done"}, seen, 0);
  endtask

  task automatic run_scan(input logic [15:0] exp_v, input logic [15:0] lut_v,
                          input bit repulse, input string name);
    int          c0;
    int          dcyc  [3];
    int          ndone [3];
    int          mono_bad = 0;
    logic [3:0]  prev;
    logic [3:0]  nxt;
    lut      = lut_v;
    expected = exp_v;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0    = cyc;
    check_eq({name, "_busy_on"}, busy_w[0], 1);
    // The registered copy must be used; scramble the live input.
    expected = 16'($urandom);
    prev = abcd_w[0];
    for (int k = 0; k < 3; k++) begin
      dcyc[k]  = -1;
      ndone[k] = 0;
    end
    for (int n = 1; n <= 110; n++) begin
      start = repulse && (n == 10 || n == 30);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) begin
          ndone[k]++;
          if (dcyc[k] < 0) dcyc[k] = cyc - c0;
        end
      end
      nxt = prev + 4'd1;
      if (abcd_w[0] != prev && abcd_w[0] != nxt) mono_bad++;
      prev = abcd_w[0];
    end
    start = 1'b0;
    check_eq({name, "_abcd_mono"}, mono_bad, 0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_lat_s%0d", name, settle_of(k)), dcyc[k], 16 * (settle_of(k) + 1) + 1);
      check_eq($sformatf("%s_ndone_s%0d", name, settle_of(k)), ndone[k], 1);
      check_eq($sformatf("%s_table_s%0d", name, settle_of(k)), table_w[k], lut_v);
      check_eq($sformatf("%s_match_s%0d", name, settle_of(k)), match_w[k], lut_v == exp_v);
      check_eq($sformatf("%s_busy_off_s%0d", name, settle_of(k)), busy_w[k], 0);
      check_eq($sformatf("%s_abcd_hold_s%0d", name, settle_of(k)), abcd_w[k], 15);
`ifdef TRUTH_TABLE_ERRCNT_EN
      check_eq($sformatf("%s_err_s%0d", name, settle_of(k)), err_w[k], popcount16(lut_v ^ exp_v));
`endif
    end
  endtask

  task automatic reset_mid_scan();
    lut      = tt_lab();
    expected = LAB_GOLDEN_TT;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rstmid");
    watch_no_done("rstmid", 60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] l;
    logic [15:0] e;
    rst      = 1'b1;
    start    = 1'b0;
    expected = '0;
    lut      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    watch_no_done("reset", 5);

    run_scan(LAB_GOLDEN_TT, tt_lab(), 1'b0, "pass");
    run_scan(16'hF000, tt_lab(), 1'b0, "fail");
    run_scan(LAB_GOLDEN_TT, tt_lab(), 1'b1, "ignstart");
    reset_mid_scan();
    run_scan(LAB_GOLDEN_TT, tt_lab(), 1'b0, "after_rst");
    run_scan(16'h55AA, tt_xor_ad(), 1'b0, "xor_ad");
    run_scan(16'hFFFF, 16'h0000, 1'b0, "all_wrong");
    for (int r = 0; r < 6; r++) begin
      l = 16'($urandom);
      e = (r % 2 == 0) ? l : 16'($urandom);
      run_scan(e, l, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
